reg_load_arbiter: RTL



---
 rtl/reg_load_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter
// Round-robin arbiter sharing one W-bit parallel-load register between N
// requesters. Each grant produces a registered load strobe plus the winner's
// data. A requester holding lock during its grant keeps ownership (LOCKED)
// for multi-word bursts.
//
// Optional macro: REG_ARB_FIXED_PRIORITY_EN -- when defined the round-robin
// pointer is frozen at 0, so the lowest requesting index always wins.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   req       in   [N]   per-requester load request (level)
//   lock      in   [N]   ownership lock, only honoured for the granted requester
//   req_data  in   [N*W] requester data, slice i = [i*W +: W]
//   gnt       out  [N]   registered one-hot grant, zero when idle
//   load      out        registered load strobe to the shared register
//   load_data out  [W]   registered load data, valid when load=1
//   owner     out  [IW]  index of the last granted requester
//   busy      out        high in GRANT or LOCKED
module reg_load_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 4,
    parameter int unsigned IW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*W-1:0]  req_data,
    output logic [N-1:0]    gnt,
    output logic            load,
    output logic [W-1:0]    load_data,
    output logic [IW-1:0]   owner,
    output logic            busy
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrant  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    localparam logic [IW:0] NVal = (IW+1)'(N);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          load_q, load_d;
    logic [W-1:0]  load_data_q, load_data_d;
    logic [IW-1:0] owner_q, owner_d;

    logic [W-1:0]  data_arr [N];
    logic          arb_any;
    logic [IW-1:0] arb_idx;
    logic [IW:0]   cand;
    logic [IW:0]   ptr_next;
    logic          rearb;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_arr[i] = req_data[i*W +: W];
        end
    end

    // Walk the search order backwards so the earliest match (closest to
    // rr_ptr) is the one left standing.
    always_comb begin
        arb_any = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (cand >= NVal) begin
                cand = cand - NVal;
            end
            if (req[cand[IW-1:0]]) begin
                arb_any = 1'b1;
                arb_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = {1'b0, arb_idx} + (IW+1)'(1);
        if (ptr_next >= NVal) begin
            ptr_next = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        load_d      = 1'b0;
        load_data_d = load_data_q;
        owner_d     = owner_q;
        rearb       = 1'b0;

        case (state_q)
            StIdle: begin
                rearb = 1'b1;
            end
            StGrant: begin
                if (lock[owner_q] && req[owner_q]) begin
                    state_d     = StLocked;
                    load_d      = 1'b1;
                    load_data_d = data_arr[owner_q];
                end else begin
                    rearb = 1'b1;
                end
            end
            StLocked: begin
                if (lock[owner_q]) begin
                    load_d      = req[owner_q];
                    load_data_d = data_arr[owner_q];
                end else begin
                    rearb = 1'b1;
                end
            end
            default: begin
                rearb = 1'b1;
            end
        endcase

        if (rearb) begin
            if (arb_any) begin
                state_d        = StGrant;
                gnt_d          = '0;
                gnt_d[arb_idx] = 1'b1;
                load_d         = 1'b1;
                load_data_d    = data_arr[arb_idx];
                owner_d        = arb_idx;
`ifdef REG_ARB_FIXED_PRIORITY_EN
                rr_ptr_d       = '0;
`else
                rr_ptr_d       = ptr_next[IW-1:0];
`endif
            end else begin
                state_d = StIdle;
                gnt_d   = '0;
                load_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            load_q      <= 1'b0;
            load_data_q <= '0;
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
            owner_q     <= owner_d;
        end
    end

    assign gnt       = gnt_q;
    assign load      = load_q;
    assign load_data = load_data_q;
    assign owner     = owner_q;
    assign busy      = (state_q != StIdle);

endmodule
